// File: rtl/capture_readout.sv
`timescale 1ns/1ps
// Capture-buffer read engine: streams LENGTH words from the RAM read port, wrapping at
// MEM_DEPTH, onto a valid/ready stream through a credit-controlled skid FIFO.
module capture_readout #(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned MEM_DEPTH  = 128,
  parameter  int unsigned RD_LATENCY = 1,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW         = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW:0]           length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_wr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CRW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam int unsigned PD  = RD_LATENCY + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic [AW:0]           r_remaining;
  logic [PD-1:0]         r_pipe_vld;
  logic [PD-1:0]         r_pipe_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [CW-1:0]         r_fifo_cnt;
  logic                  r_m_valid;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_load;
  logic                  w_issue_last;
  logic                  w_done_nxt;
  logic                  w_credit_ok;
  logic [CRW-1:0]        w_in_flight;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_wr_idx;

  // Pipe stage 0 is the cycle ram_addr presents a freshly issued address; the last stage
  // lines up with valid ram_dout, so the pipe is one stage longer than the RAM latency.
  always_comb begin
    w_pop       = r_m_valid & m_ready;
    w_push      = r_pipe_vld[PD-1];
    w_in_flight = '0;
    for (int i = 0; i < int'(PD); i++) begin
      w_in_flight = w_in_flight + CRW'(r_pipe_vld[i]);
    end
    w_credit_ok = (CRW'(r_fifo_cnt) + w_in_flight - CRW'(w_pop)) < CRW'(FIFO_DEPTH);
    w_cnt_nxt   = r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    w_wr_idx    = IW'(r_fifo_cnt - CW'(w_pop));
  end

  // Next-state and issue control; abort overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    w_issue_last = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_issue      = 1'b1;
            w_issue_last = (length == (AW+1)'(1));
            w_state_nxt  = (length == (AW+1)'(1)) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_credit_ok) begin
          w_issue      = 1'b1;
          w_issue_last = (r_remaining == (AW+1)'(1));
          if (r_remaining == (AW+1)'(1)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && r_fifo_last[0] && (r_fifo_cnt == CW'(1)) && (w_in_flight == '0)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_issue      = 1'b0;
      w_load       = 1'b0;
      w_issue_last = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // Address wraps naturally because MEM_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_addr      <= start_addr;
      r_remaining <= length - (AW+1)'(1);
    end else if (w_issue) begin
      r_addr      <= r_addr + AW'(1);
      r_remaining <= r_remaining - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else if (abort) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld  <= {r_pipe_vld[PD-2:0], w_issue};
      r_pipe_last <= {r_pipe_last[PD-2:0], w_issue_last};
    end
  end

  // Shift FIFO: entry 0 is the head and drives the stream outputs directly.
  // Last flags above the fill level are kept at zero so m_last never shows a stale flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_fifo_cnt  <= '0;
      r_m_valid   <= 1'b0;
    end else if (abort) begin
      r_fifo_last <= '0;
      r_fifo_cnt  <= '0;
      r_m_valid   <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          r_fifo_data[i] <= r_fifo_data[i+1];
        end
        r_fifo_last <= {1'b0, r_fifo_last[FIFO_DEPTH-1:1]};
      end
      if (w_push) begin
        r_fifo_data[w_wr_idx] <= ram_dout;
        r_fifo_last[w_wr_idx] <= r_pipe_last[PD-1];
      end
      r_fifo_cnt <= w_cnt_nxt;
      r_m_valid  <= (w_cnt_nxt != '0);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ram_addr = r_addr;
  assign ram_wr   = 1'b0;
  assign m_data   = r_fifo_data[0];
  assign m_valid  = r_m_valid;
  assign m_last   = r_fifo_last[0];

endmodule

// File: tb/tb_capture_readout.sv
`timescale 1ns/1ps
// Directed bench for capture_readout: one instance at RD_LATENCY=1, one at RD_LATENCY=2,
// sharing the command and ready inputs; each has its own RAM model.
module tb_capture_readout;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 7;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          m_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;

  logic          busy1, done1, ram_wr1, m_valid1, m_last1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_dout1, m_data1;

  logic          busy2, done2, ram_wr2, m_valid2, m_last2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_dout2, ram_q2, m_data2;

  int n_checks;
  int n_fail;

  function automatic logic [DW-1:0] word(input int a);
    return {16'hC0DE, 16'(a * 37), 32'(a) ^ 32'h5A5A_0000};
  endfunction

  capture_readout #(.DATA_WIDTH(64), .MEM_DEPTH(128), .RD_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .abort(abort), .busy(busy1), .done(done1), .ram_addr(ram_addr1), .ram_wr(ram_wr1),
    .ram_dout(ram_dout1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready)
  );

  capture_readout #(.DATA_WIDTH(64), .MEM_DEPTH(128), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .abort(abort), .busy(busy2), .done(done2), .ram_addr(ram_addr2), .ram_wr(ram_wr2),
    .ram_dout(ram_dout2), .m_data(m_data2), .m_valid(m_valid2), .m_last(m_last2),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_dout1 <= word(int'(ram_addr1));
    ram_q2    <= word(int'(ram_addr2));
    ram_dout2 <= ram_q2;
  end

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    start_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy1, done1, m_valid1, m_last1, ram_wr1} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl1: got %b expected 00000", {busy1, done1, m_valid1, m_last1, ram_wr1});
    end
    n_checks++;
    if (ram_addr1 !== 7'd0) begin
      n_fail++; $display("FAIL reset_addr1: got %0d expected 0", ram_addr1);
    end
    n_checks++;
    if (m_data1 !== 64'd0) begin
      n_fail++; $display("FAIL reset_data1: got %h expected 0", m_data1);
    end
    n_checks++;
    if ({busy2, done2, m_valid2, m_last2, ram_wr2} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl2: got %b expected 00000", {busy2, done2, m_valid2, m_last2, ram_wr2});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy1, done1, m_valid1} !== 3'b0) begin
      n_fail++; $display("FAIL reset_release: got %b expected 000", {busy1, done1, m_valid1});
    end
  endtask

  task automatic test_basic;
    logic exp_v;
    m_ready = 1'b1; start_addr = 7'd5; length = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ram_addr1 !== 7'd5) begin
      n_fail++; $display("FAIL basic_addr: got %0d expected 5", ram_addr1);
    end
    for (int n = 0; n <= 7; n++) begin
      if (n > 0) @(negedge clk);
      exp_v = (n >= 2 && n <= 5);
      n_checks++;
      if (m_valid1 !== exp_v) begin
        n_fail++; $display("FAIL basic_valid n=%0d: got %b expected %b", n, m_valid1, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (m_data1 !== word(5 + n - 2)) begin
          n_fail++; $display("FAIL basic_data n=%0d: got %h expected %h", n, m_data1, word(5 + n - 2));
        end
        n_checks++;
        if (m_last1 !== (n == 5)) begin
          n_fail++; $display("FAIL basic_last n=%0d: got %b expected %b", n, m_last1, (n == 5));
        end
      end
      n_checks++;
      if (done1 !== (n == 6)) begin
        n_fail++; $display("FAIL basic_done n=%0d: got %b expected %b", n, done1, (n == 6));
      end
      n_checks++;
      if (busy1 !== (n <= 5)) begin
        n_fail++; $display("FAIL basic_busy n=%0d: got %b expected %b", n, busy1, (n <= 5));
      end
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_a;
    start_addr = 7'd126; length = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk);
      if (n < 4) begin
        exp_a = 7'(126 + n);
        n_checks++;
        if (ram_addr1 !== exp_a) begin
          n_fail++; $display("FAIL wrap_addr n=%0d: got %0d expected %0d", n, ram_addr1, exp_a);
        end
      end
      if (n >= 2 && n <= 5) begin
        n_checks++;
        if (m_valid1 !== 1'b1 || m_data1 !== word((126 + n - 2) % 128)) begin
          n_fail++; $display("FAIL wrap_data n=%0d: got v=%b %h expected v=1 %h", n, m_valid1, m_data1, word((126 + n - 2) % 128));
        end
      end
    end
    n_checks++;
    if (done1 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: got %b expected 1", done1);
    end
  endtask

  task automatic test_zero;
    start_addr = 7'd9; length = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done1, busy1, m_valid1} !== 3'b100) begin
      n_fail++; $display("FAIL zero_pulse: got done,busy,valid=%b expected 100", {done1, busy1, m_valid1});
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({done1, busy1, m_valid1} !== 3'b000) begin
        n_fail++; $display("FAIL zero_after n=%0d: got %b expected 000", n, {done1, busy1, m_valid1});
      end
    end
  endtask

  task automatic test_abort;
    m_ready = 1'b1; start_addr = 7'd40; length = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 5; n++) begin
      if (n > 0) @(negedge clk);
      if (n >= 2 && n <= 4) begin
        n_checks++;
        if (m_valid1 !== 1'b1 || m_data1 !== word(40 + n - 2)) begin
          n_fail++; $display("FAIL abort_pre n=%0d: got v=%b %h expected v=1 %h", n, m_valid1, m_data1, word(40 + n - 2));
        end
      end
    end
    // three beats accepted; hold the fourth and abort
    m_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; m_ready = 1'b1;
    n_checks++;
    if ({m_valid1, busy1, done1} !== 3'b000) begin
      n_fail++; $display("FAIL abort_next: got valid,busy,done=%b expected 000", {m_valid1, busy1, done1});
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if ({m_valid1, busy1, done1} !== 3'b000) begin
        n_fail++; $display("FAIL abort_quiet n=%0d: got %b expected 000", n, {m_valid1, busy1, done1});
      end
    end
    start_addr = 7'd60; length = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) @(negedge clk);
      n_checks++;
      if (m_valid1 !== (n == 2 || n == 3)) begin
        n_fail++; $display("FAIL abort_fresh_valid n=%0d: got %b expected %b", n, m_valid1, (n == 2 || n == 3));
      end
      if (n == 2 || n == 3) begin
        n_checks++;
        if (m_data1 !== word(60 + n - 2) || m_last1 !== (n == 3)) begin
          n_fail++; $display("FAIL abort_fresh_data n=%0d: got %h last=%b expected %h last=%b", n, m_data1, m_last1, word(60 + n - 2), (n == 3));
        end
      end
    end
    n_checks++;
    if (done1 !== 1'b1) begin
      n_fail++; $display("FAIL abort_fresh_done: got %b expected 1", done1);
    end
    // start and abort together while idle: abort wins
    start_addr = 7'd0; length = 8'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      n_checks++;
      if ({m_valid1, busy1, done1} !== 3'b000) begin
        n_fail++; $display("FAIL start_abort n=%0d: got %b expected 000", n, {m_valid1, busy1, done1});
      end
    end
  endtask

  task automatic test_full;
    logic exp_v;
    m_ready = 1'b1; start_addr = 7'd0; length = 8'd128; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 132; n++) begin
      if (n > 0) @(negedge clk);
      exp_v = (n >= 2 && n <= 129);
      n_checks++;
      if (m_valid1 !== exp_v) begin
        n_fail++; $display("FAIL full_valid n=%0d: got %b expected %b", n, m_valid1, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (m_data1 !== word(n - 2) || m_last1 !== (n == 129)) begin
          n_fail++; $display("FAIL full_data n=%0d: got %h last=%b expected %h last=%b", n, m_data1, m_last1, word(n - 2), (n == 129));
        end
      end
      n_checks++;
      if (done1 !== (n == 130) || busy1 !== (n <= 129)) begin
        n_fail++; $display("FAIL full_ctrl n=%0d: got done=%b busy=%b expected done=%b busy=%b", n, done1, busy1, (n == 130), (n <= 129));
      end
      if (n == 50) begin
        start_addr = 7'd9; length = 8'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0]   pat;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          stalled;
    logic          done_seen;
    int            k;
    int            first_n;
    pat = 32'hB2E5_396D;
    prev_data = '0; prev_last = 1'b0; stalled = 1'b0; done_seen = 1'b0;
    k = 0; first_n = -1;
    rst = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_addr = 7'd20; length = 8'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (m_valid2 !== 1'b1 || m_data2 !== prev_data || m_last2 !== prev_last) begin
          n_fail++; $display("FAIL bp_stable n=%0d: got v=%b %h last=%b expected v=1 %h last=%b", n, m_valid2, m_data2, m_last2, prev_data, prev_last);
        end
      end
      if (m_valid2 === 1'b1) begin
        if (first_n < 0) first_n = n;
        n_checks++;
        if (k >= 16 || m_data2 !== word(20 + k) || m_last2 !== (k == 15)) begin
          n_fail++; $display("FAIL bp_beat k=%0d: got %h last=%b expected %h last=%b", k, m_data2, m_last2, word(20 + k), (k == 15));
        end
      end
      if (done2 === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      m_ready   = pat[n % 32];
      stalled   = m_valid2 && !m_ready;
      prev_data = m_data2;
      prev_last = m_last2;
      if (m_valid2 && m_ready) k++;
    end
    n_checks++;
    if (!done_seen) begin
      n_fail++; $display("FAIL bp_timeout: done got 0 expected 1 within 300 cycles");
    end
    n_checks++;
    if (k != 16) begin
      n_fail++; $display("FAIL bp_count: got %0d beats expected 16", k);
    end
    n_checks++;
    if (first_n != 3) begin
      n_fail++; $display("FAIL bp_latency: first valid got %0d expected 3", first_n);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({m_valid2, busy2} !== 2'b00) begin
        n_fail++; $display("FAIL bp_after n=%0d: got valid,busy=%b expected 00", n, {m_valid2, busy2});
      end
    end
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b1; start_addr = 7'd100; length = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy1, done1, m_valid1, m_last1} !== 4'b0 || ram_addr1 !== 7'd0) begin
      n_fail++; $display("FAIL rstmid_async: got ctrl=%b addr=%0d expected 0000 0", {busy1, done1, m_valid1, m_last1}, ram_addr1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      n_checks++;
      if ({busy1, done1, m_valid1} !== 3'b000) begin
        n_fail++; $display("FAIL rstmid_quiet n=%0d: got %b expected 000", n, {busy1, done1, m_valid1});
      end
    end
    // single-word readout after the reset
    start_addr = 7'd3; length = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m_valid1 !== 1'b1 || m_last1 !== 1'b1 || m_data1 !== word(3)) begin
      n_fail++; $display("FAIL single_beat: got v=%b last=%b %h expected v=1 last=1 %h", m_valid1, m_last1, m_data1, word(3));
    end
    @(negedge clk);
    n_checks++;
    if ({done1, busy1, m_valid1} !== 3'b100) begin
      n_fail++; $display("FAIL single_done: got done,busy,valid=%b expected 100", {done1, busy1, m_valid1});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_abort();
    test_full();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
